// File: rtl/slot_pkg.sv
// Shared definitions for the TDM slot scheduler.
//   NUM_REQ / NUM_SLOTS : requester count and frame length
//   slot_t / owner_t    : slot index and requester index types
//   slot_entry_t        : one slot-table entry {en, owner}
//   owner_onehot()      : requester index to one-hot grant vector
package slot_pkg;

    localparam int NUM_REQ   = 4;
    localparam int NUM_SLOTS = 13;

    typedef logic [3:0] slot_t;
    typedef logic [1:0] owner_t;

    typedef struct packed {
        logic   en;
        owner_t owner;
    } slot_entry_t;

    localparam slot_t LAST_SLOT = 4'd12;

    function automatic logic [3:0] owner_onehot(input owner_t o);
        logic [3:0] v;
        case (o)
            2'd0:    v = 4'b0001;
            2'd1:    v = 4'b0010;
            2'd2:    v = 4'b0100;
            2'd3:    v = 4'b1000;
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/slot_scheduler_if.sv
// Bus bundle for slot_scheduler.
//   master : frame control, requests and slot-table writes driven in,
//            grant/slot/rr_used observed.
//   slave  : the scheduler side of the same signals.
interface slot_scheduler_if;
    import slot_pkg::*;

    logic        run;
    logic [3:0]  req;
    logic        cfg_we;
    slot_t       cfg_addr;
    owner_t      cfg_owner;
    logic        cfg_en;
    logic [3:0]  gnt;
    slot_t       slot;
    logic        rr_used;

    modport master (
        output run, req, cfg_we, cfg_addr, cfg_owner, cfg_en,
        input  gnt, slot, rr_used
    );

    modport slave (
        input  run, req, cfg_we, cfg_addr, cfg_owner, cfg_en,
        output gnt, slot, rr_used
    );

endinterface

// File: rtl/slot_counter.sv
// Mod-13 TDM slot counter.
//   clock : rising-edge clock
//   reset : synchronous active-high reset, counter returns to slot 0
//   run   : advance enable, counter holds while low
//   count : current slot index 0..12
import slot_pkg::*;

module slot_counter (
    input  logic  clock,
    input  logic  reset,
    input  logic  run,
    output slot_t count
);

    slot_t count_r;

    // Slot index: wraps from the last slot back to 0, frozen while run is low.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= 4'd0;
        end else if (run) begin
            if (count_r == LAST_SLOT) begin
                count_r <= 4'd0;
            end else begin
                count_r <= count_r + 4'd1;
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/slot_scheduler.sv
// TDM slot scheduler with round-robin fallback.
//   clock : rising-edge clock
//   reset : synchronous active-high reset (wins over run and cfg writes)
//   bus   : slave side of slot_scheduler_if
//           run/req in, cfg_we/cfg_addr/cfg_owner/cfg_en slot-table write,
//           gnt/slot/rr_used registered result, one cycle after sampling.
// Each slot has a reserved owner; if that owner is idle or the slot is not
// reserved, the slot is offered round-robin to the other requesters.
import slot_pkg::*;

module slot_scheduler #(
    parameter int NUM_REQ   = slot_pkg::NUM_REQ,
    parameter int NUM_SLOTS = slot_pkg::NUM_SLOTS
) (
    input  logic              clock,
    input  logic              reset,
    slot_scheduler_if.slave   bus
);

    slot_t       count_s;
    slot_entry_t table_r [NUM_SLOTS];
    slot_entry_t cur_entry_s;

    logic [3:0]  gnt_r;
    slot_t       slot_r;
    logic        rr_used_r;
    owner_t      rr_ptr_r;

    logic        owner_hit_s;
    logic        rr_found_s;
    owner_t      rr_sel_s;
    logic [3:0]  gnt_next_s;
    logic        rr_used_next_s;
    owner_t      rr_ptr_next_s;

    slot_counter u_counter (
        .clock (clock),
        .reset (reset),
        .run   (bus.run),
        .count (count_s)
    );

    // The entry read here is the pre-write value, so a write to the slot
    // under arbitration only takes effect at that slot's next visit.
    assign cur_entry_s = table_r[count_s];

    // Slot table: reset to one reserved slot per requester in rotation;
    // writes to indices past the last slot are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                table_r[i].en    <= 1'b1;
                table_r[i].owner <= owner_t'(i % NUM_REQ);
            end
        end else if (bus.cfg_we && (bus.cfg_addr <= LAST_SLOT)) begin
            table_r[bus.cfg_addr].en    <= bus.cfg_en;
            table_r[bus.cfg_addr].owner <= bus.cfg_owner;
        end else begin
            table_r <= table_r;
        end
    end

    // Round-robin search: first requester at or after rr_ptr. Scanning the
    // offsets downward lets the smallest offset be the last one written.
    always_comb begin
        rr_found_s = 1'b0;
        rr_sel_s   = rr_ptr_r;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[rr_ptr_r + owner_t'(i)]) begin
                rr_found_s = 1'b1;
                rr_sel_s   = rr_ptr_r + owner_t'(i);
            end else begin
                rr_found_s = rr_found_s;
            end
        end
    end

    // Grant decision: reserved owner first, then round-robin, else idle.
    always_comb begin
        owner_hit_s    = cur_entry_s.en && bus.req[cur_entry_s.owner];
        gnt_next_s     = 4'b0000;
        rr_used_next_s = 1'b0;
        rr_ptr_next_s  = rr_ptr_r;
        if (!bus.run) begin
            gnt_next_s = 4'b0000;
        end else if (owner_hit_s) begin
            gnt_next_s = owner_onehot(cur_entry_s.owner);
        end else if (rr_found_s) begin
            gnt_next_s     = owner_onehot(rr_sel_s);
            rr_used_next_s = 1'b1;
            rr_ptr_next_s  = rr_sel_s + 2'd1;
        end else begin
            gnt_next_s = 4'b0000;
        end
    end

    // Registered outputs and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_r     <= 4'b0000;
            slot_r    <= 4'd0;
            rr_used_r <= 1'b0;
            rr_ptr_r  <= 2'd0;
        end else begin
            gnt_r     <= gnt_next_s;
            slot_r    <= count_s;
            rr_used_r <= rr_used_next_s;
            rr_ptr_r  <= rr_ptr_next_s;
        end
    end

    assign bus.gnt     = gnt_r;
    assign bus.slot    = slot_r;
    assign bus.rr_used = rr_used_r;

endmodule

// File: tb/tb_slot_scheduler.sv
module tb_slot_scheduler;
    import slot_pkg::*;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    slot_scheduler_if bus ();

    slot_scheduler dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] slot;
        logic       rr;
    } exp_t;

    exp_t  sb_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "reset";

    // reference model state
    logic       m_en  [13];
    logic [1:0] m_own [13];
    int         m_cnt;
    int         m_ptr;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d expected %0d", phase, tag, obs, exp);
        end
    endtask

    task automatic model_defaults();
        for (int i = 0; i < 13; i++) begin
            m_en[i]  = 1'b1;
            m_own[i] = 2'(i % 4);
        end
        m_cnt = 0;
        m_ptr = 0;
    endtask

    // Predict this cycle's result, push it, clock, then compare.
    task automatic step();
        exp_t e;
        exp_t got;
        int   idx;
        e = '0;
        if (reset) begin
            model_defaults();
        end else begin
            e.slot = 4'(m_cnt);
            if (bus.run) begin
                if (m_en[m_cnt] && bus.req[m_own[m_cnt]]) begin
                    e.gnt = 4'b0001 << m_own[m_cnt];
                end else if (bus.req != 4'b0000) begin
                    for (int k = 0; k < 4; k++) begin
                        idx = (m_ptr + k) % 4;
                        if (bus.req[idx] && !e.rr) begin
                            e.gnt = 4'b0001 << idx;
                            e.rr  = 1'b1;
                            m_ptr = (idx + 1) % 4;
                        end
                    end
                end
                m_cnt = (m_cnt == 12) ? 0 : m_cnt + 1;
            end
            if (bus.cfg_we && bus.cfg_addr <= 4'd12) begin
                m_en[bus.cfg_addr]  = bus.cfg_en;
                m_own[bus.cfg_addr] = bus.cfg_owner;
            end
        end
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        got = sb_q.pop_front();
        check_val("gnt", int'(bus.gnt), int'(got.gnt));
        check_val("slot", int'(bus.slot), int'(got.slot));
        check_val("rr_used", int'(bus.rr_used), int'(got.rr));
        check_val("onehot", int'($countones(bus.gnt) <= 1), 1);
    endtask

    task automatic go_to_slot(input int s);
        for (int n = 0; n < 14 && m_cnt != s; n++) begin
            step();
        end
        check_val("reach_slot", m_cnt, s);
    endtask

    task automatic cfg_idle();
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = 4'd0;
        bus.cfg_owner = 2'd0;
        bus.cfg_en    = 1'b0;
    endtask

    initial begin
        model_defaults();
        reset   = 1'b1;
        bus.run = 1'b0;
        bus.req = 4'b0000;
        cfg_idle();
        step();
        step();
        reset = 1'b0;

        phase   = "all_req";
        bus.run = 1'b1;
        bus.req = 4'b1111;
        repeat (13) step();

        phase   = "single_req";
        bus.req = 4'b0100;
        repeat (13) step();

        phase   = "rr_only";
        reset   = 1'b1;
        step();
        reset   = 1'b0;
        bus.run = 1'b0;
        bus.req = 4'b0000;
        for (int i = 0; i < 13; i++) begin
            bus.cfg_we    = 1'b1;
            bus.cfg_addr  = 4'(i);
            bus.cfg_en    = 1'b0;
            bus.cfg_owner = 2'(i % 4);
            step();
        end
        cfg_idle();
        bus.run = 1'b1;
        bus.req = 4'b1010;
        repeat (6) step();

        phase   = "write_hazard";
        reset   = 1'b1;
        step();
        reset   = 1'b0;
        bus.req = 4'b1111;
        go_to_slot(5);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 4'd5;
        bus.cfg_en    = 1'b1;
        bus.cfg_owner = 2'd3;
        step();
        cfg_idle();
        repeat (13) step();

        phase = "run_pause";
        go_to_slot(7);
        bus.run = 1'b0;
        step();
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 4'd14;
        bus.cfg_en    = 1'b0;
        bus.cfg_owner = 2'd0;
        step();
        cfg_idle();
        step();
        bus.run = 1'b1;
        repeat (14) step();

        phase = "reset_vs_write";
        go_to_slot(9);
        reset         = 1'b1;
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 4'd2;
        bus.cfg_en    = 1'b0;
        bus.cfg_owner = 2'd3;
        step();
        reset = 1'b0;
        cfg_idle();
        repeat (13) step();

        phase = "random";
        for (int n = 0; n < 300; n++) begin
            reset         = ($urandom_range(0, 49) == 0);
            bus.run       = ($urandom_range(0, 4) != 0);
            bus.req       = 4'($urandom_range(0, 15));
            bus.cfg_we    = ($urandom_range(0, 3) == 0);
            bus.cfg_addr  = 4'($urandom_range(0, 15));
            bus.cfg_en    = 1'($urandom_range(0, 1));
            bus.cfg_owner = 2'($urandom_range(0, 3));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/slot_scheduler.md
SLOT_SCHEDULER -- requirements
Module: slot_scheduler

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters sharing the resource (fixed at 4 in this revision).
REQ-002 Parameter NUM_SLOTS, default 13, TDM frame length in slots (fixed at 13 in this revision).
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run  input  1  frame advance enable; low freezes the slot counter and suppresses grants.
REQ-006 req  input  4  per-requester request, level-sensitive.
REQ-007 cfg_we  input  1  slot-table write strobe.
REQ-008 cfg_addr  input  4  slot-table index to write, 0..12.
REQ-009 cfg_owner  input  2  owner requester written to the table entry.
REQ-010 cfg_en  input  1  reserved-slot enable bit written to the table entry.
REQ-011 gnt  output  4  registered one-hot grant, or all-zero.
REQ-012 slot  output  4  registered index of the slot that gnt belongs to, 0..12.
REQ-013 rr_used  output  1  registered; high when gnt came from round-robin fallback rather than from the table owner.

Function
REQ-014 The internal slot counter SHALL advance 0,1,...,12,0 on each clock with run=1 and SHALL hold its value with run=0.
REQ-015 The slot table SHALL hold 13 entries of {en, owner[1:0]}.
REQ-016 Arbitration for slot s SHALL use req and table[s] sampled in the same cycle, and SHALL register gnt/slot/rr_used on that edge, giving 1-cycle latency.
REQ-017 If table[s].en=1 and req[owner]=1, gnt SHALL be one-hot at owner with rr_used=0.
REQ-018 Otherwise, if any req bit is set, gnt SHALL go to the first requesting index at or after rr_ptr (mod 4) with rr_used=1, and rr_ptr SHALL update to granted index+1 mod 4.
REQ-019 rr_ptr SHALL change only on round-robin grants; owner grants leave it unchanged.
REQ-020 With req=0, or with run=0, gnt SHALL be 0 and rr_used SHALL be 0; slot SHALL still show the current counter value.
REQ-021 gnt SHALL never have more than one bit set.
REQ-022 A cfg_we with cfg_addr<=12 SHALL update the entry on the clock edge; cfg_addr 13..15 SHALL be ignored.
REQ-023 A write to the entry being arbitrated in that cycle SHALL NOT affect that cycle's grant; the new value applies from the entry's next use.
REQ-024 Configuration writes SHALL be accepted regardless of run.

Reset
REQ-025 On reset: slot counter=0, slot=0, gnt=0, rr_used=0, rr_ptr=0.
REQ-026 On reset: table[i] SHALL be {en=1, owner=i mod 4} for i=0..12.
REQ-027 Reset SHALL take priority over run and cfg_we in the same cycle, and SHALL abort any frame in progress.

Structure
REQ-028 Package slot_pkg SHALL define NUM_REQ, NUM_SLOTS, typedef slot_t (4-bit), owner_t (2-bit), and the struct slot_entry_t {en, owner}.
REQ-029 The mod-13 counter SHALL be a sub-module slot_counter (clock, reset, run, count[3:0]).
REQ-030 Arbitration logic SHALL be in the top module; the table SHALL be a flop array with no memory macro.

Verification
REQ-031 Reset, then run=1, req=4'b1111 for 13 cycles -> gnt cycles 0001,0010,0100,1000,... with slot 0..12 and rr_used=0 throughout.
REQ-032 Default table, req=4'b0100 constant -> slot 2,6,10 owner grants with rr_used=0; all other slots grant 0100 with rr_used=1.
REQ-033 req=4'b1010, rr_ptr=0, table[0..12].en=0 -> grants alternate 0010,1000,0010; rr_ptr follows 2,0,2.
REQ-034 Write table[5]={1,3} in the cycle slot 5 is arbitrated with req=4'b1111 -> that grant is 0010 (old owner 1); at slot 5 of the next frame the grant is 1000.
REQ-035 run dropped at slot 7 for 3 cycles -> gnt=0, slot holds 7; on resume slot continues 7,8; a write with cfg_addr=14 leaves the table unchanged.
REQ-036 reset asserted at slot 9 with cfg_we=1 -> next cycle slot=0, gnt=0, table at defaults, write discarded.
